// File: rtl/sm_warp_scheduler_pkg.sv
// Shared constants for the SM warp issue scheduler and its arbiter.
//   NUM_WARP_DEF   : default warps per SM
//   DEPTH_WARP_DEF : default warp id width, clog2(NUM_WARP_DEF)
//   BARRIER_ENABLE : 0 compiles barrier parking out (waiting stays 0)
package sm_warp_scheduler_pkg;

  localparam int NUM_WARP_DEF   = 8;
  localparam int DEPTH_WARP_DEF = $clog2(NUM_WARP_DEF);
  localparam bit BARRIER_ENABLE = 1'b1;

endpackage

// File: rtl/sm_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches req starting at ptr+1 and wraps modulo N; the first set bit wins.
//   req      [N]  request vector
//   ptr      [W]  last granted index (lowest priority this round)
//   grant_oh [N]  one-hot grant, zero when nothing requests
//   grant_id [W]  index of the grant, zero when nothing requests
//   any           at least one request present
module sm_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_id,
  output logic         any
);

  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                          = 1'b1;
        grant_oh[(int'(ptr) + i) % N] = 1'b1;
        grant_id                     = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sm_warp_scheduler.sv
// Per-SM warp issue scheduler. Tracks active and barrier-parked warps,
// picks one eligible warp per cycle round-robin and presents it on a
// registered valid/ready port; pops the instruction buffer on handshake.
//   clk, rst_n                      clock, async active-low reset
//   warp_start_valid_i/_wid_i       warp launch
//   warp_end_valid_i/_wid_i         warp retire (EXIT)
//   barrier_valid_i/_wid_i          warp reached BAR
//   inst_buffer_has_data_i [NW]     per-warp buffer non-empty
//   stalled_warps_i        [NW]     scoreboard hazard mask
//   issue_valid_o/_wid_o, issue_ready_i   issue handshake
//   warp_to_issue_oh_o     [NW]     one-hot buffer pop
//   active_warps_o, barrier_waiting_o     status masks
module sm_warp_scheduler
  import sm_warp_scheduler_pkg::*;
#(
  parameter int NUM_WARP   = NUM_WARP_DEF,
  parameter int DEPTH_WARP = DEPTH_WARP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  warp_start_valid_i,
  input  logic [DEPTH_WARP-1:0] warp_start_wid_i,
  input  logic                  warp_end_valid_i,
  input  logic [DEPTH_WARP-1:0] warp_end_wid_i,
  input  logic                  barrier_valid_i,
  input  logic [DEPTH_WARP-1:0] barrier_wid_i,
  input  logic [NUM_WARP-1:0]   inst_buffer_has_data_i,
  input  logic [NUM_WARP-1:0]   stalled_warps_i,
  output logic                  issue_valid_o,
  output logic [DEPTH_WARP-1:0] issue_wid_o,
  input  logic                  issue_ready_i,
  output logic [NUM_WARP-1:0]   warp_to_issue_oh_o,
  output logic [NUM_WARP-1:0]   active_warps_o,
  output logic [NUM_WARP-1:0]   barrier_waiting_o
);

  logic [NUM_WARP-1:0]   active, waiting, active_next, waiting_next;
  logic [NUM_WARP-1:0]   held, eligible, grant_oh;
  logic [DEPTH_WARP-1:0] rr_ptr, grant_id;
  logic                  grant_any, handshake, load;
  logic                  grant_oh_unused;

  assign grant_oh_unused = ^grant_oh;

  // The warp sitting in the output register is excluded so a single-entry
  // buffer is never granted twice before its pop lands.
  always_comb begin
    held = '0;
    if (issue_valid_o) held[issue_wid_o] = 1'b1;
  end

  assign eligible = active & inst_buffer_has_data_i & ~stalled_warps_i
                  & ~waiting & ~held;

  sm_rr_arbiter #(.N(NUM_WARP), .W(DEPTH_WARP)) u_arb (
    .req      (eligible),
    .ptr      (rr_ptr),
    .grant_oh (grant_oh),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign handshake = issue_valid_o && issue_ready_i;
  assign load      = (!issue_valid_o || issue_ready_i) && grant_any;

  always_comb begin
    warp_to_issue_oh_o = '0;
    if (handshake) warp_to_issue_oh_o[issue_wid_o] = 1'b1;
  end

  // End is applied last so it overrides a same-cycle start or arrival.
  // Release fires once every remaining active warp is parked, including
  // the case where an end retires the last non-parked warp.
  always_comb begin
    active_next  = active;
    waiting_next = waiting;
    if (warp_start_valid_i) active_next[warp_start_wid_i] = 1'b1;
    if (BARRIER_ENABLE && barrier_valid_i && active[barrier_wid_i])
      waiting_next[barrier_wid_i] = 1'b1;
    if (warp_end_valid_i) begin
      active_next[warp_end_wid_i]  = 1'b0;
      waiting_next[warp_end_wid_i] = 1'b0;
    end
    if (|active_next && (waiting_next == active_next)) waiting_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= '0;
      waiting       <= '0;
      rr_ptr        <= DEPTH_WARP'(NUM_WARP - 1);
      issue_valid_o <= 1'b0;
      issue_wid_o   <= '0;
    end else begin
      active  <= active_next;
      waiting <= waiting_next;
      if (load) begin
        issue_valid_o <= 1'b1;
        issue_wid_o   <= grant_id;
        rr_ptr        <= grant_id;
      end else if (handshake) begin
        issue_valid_o <= 1'b0;
      end
    end
  end

  assign active_warps_o    = active;
  assign barrier_waiting_o = waiting;

endmodule
